// File: rtl/dpram_fifo_ctrl.sv
// Streaming FIFO controller around one rdpb18 dual-port SRAM (A write-only, B read-only).
// A 2-entry head/skid buffer hides the macro's one-cycle read latency.
module dpram_fifo_ctrl #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 7
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              clr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic [AWIDTH+1:0] count,
    output logic [AWIDTH-1:0] ram_aa,
    output logic              ram_csba,
    output logic              ram_weba,
    output logic              ram_reba,
    output logic              ram_oeba,
    output logic [DWIDTH-1:0] ram_ia,
    output logic [AWIDTH-1:0] ram_ab,
    output logic              ram_csbb,
    output logic              ram_rebb,
    output logic              ram_webb,
    output logic              ram_oebb,
    output logic [DWIDTH-1:0] ram_ib,
    input  logic [DWIDTH-1:0] ram_ob
);

    localparam logic [AWIDTH:0] FULL = (AWIDTH+1)'(2**AWIDTH);

    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   ram_used;
    logic              inflight;
    logic [1:0]        obuf_cnt;
    logic [DWIDTH-1:0] skid;

    logic              active;
    logic              wr_en;
    logic              rd_en;
    logic              pop;
    logic [2:0]        occ;
    logic [1:0]        obuf_left;
    logic [1:0]        obuf_nxt;
    logic [DWIDTH-1:0] head_nxt;
    logic [DWIDTH-1:0] skid_nxt;
    logic [AWIDTH:0]   used_nxt;

    assign active  = xrst & ~clr;
    assign s_ready = active & (ram_used != FULL);
    assign wr_en   = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    // Issue a read only if the word will still fit in the buffer once it lands.
    assign occ   = {1'b0, obuf_cnt} + {2'b00, inflight};
    assign rd_en = active & (ram_used != '0) & (occ <= ({2'b00, pop} + 3'd1));

    assign obuf_left = obuf_cnt - {1'b0, pop};

    always_comb begin
        obuf_nxt = obuf_left + {1'b0, inflight};
        head_nxt = m_data;
        skid_nxt = skid;
        used_nxt = ram_used;
        if (pop) begin
            head_nxt = skid;
        end
        // Returning word lands in the head if pop emptied the buffer, else in the skid.
        if (inflight) begin
            if (obuf_left == 2'd0) begin
                head_nxt = ram_ob;
            end else begin
                skid_nxt = ram_ob;
            end
        end
        case ({wr_en, rd_en})
            2'b10:   used_nxt = ram_used + 1'b1;
            2'b01:   used_nxt = ram_used - 1'b1;
            default: used_nxt = ram_used;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!xrst || clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_used <= '0;
            inflight <= 1'b0;
            obuf_cnt <= '0;
            skid     <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ram_used <= used_nxt;
            inflight <= rd_en;
            obuf_cnt <= obuf_nxt;
            skid     <= skid_nxt;
            m_data   <= head_nxt;
            m_valid  <= (obuf_nxt != 2'd0);
        end
    end

    assign count = {1'b0, ram_used} + (AWIDTH+2)'(inflight) + (AWIDTH+2)'(obuf_cnt);

    assign ram_aa   = wr_ptr;
    assign ram_csba = ~wr_en;
    assign ram_weba = ~wr_en;
    assign ram_reba = 1'b1;
    assign ram_oeba = 1'b1;
    assign ram_ia   = s_data;
    assign ram_ab   = rd_ptr;
    assign ram_csbb = ~rd_en;
    assign ram_rebb = ~rd_en;
    assign ram_webb = 1'b1;
    assign ram_oebb = 1'b0;
    assign ram_ib   = '0;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Randomized bench for dpram_fifo_ctrl: behavioural SRAM macro plus a queue-based FIFO model.
module tb_dpram_fifo_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 7;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          xrst, clr, s_valid, m_ready;
    logic [DW-1:0] s_data;
    logic          s_ready, m_valid;
    logic [DW-1:0] m_data;
    logic [AW+1:0] count;
    logic [AW-1:0] ram_aa, ram_ab;
    logic          ram_csba, ram_weba, ram_reba, ram_oeba;
    logic          ram_csbb, ram_rebb, ram_webb, ram_oebb;
    logic [DW-1:0] ram_ia, ram_ib, ram_ob;

    dpram_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .xrst(xrst), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count),
        .ram_aa(ram_aa), .ram_csba(ram_csba), .ram_weba(ram_weba),
        .ram_reba(ram_reba), .ram_oeba(ram_oeba), .ram_ia(ram_ia),
        .ram_ab(ram_ab), .ram_csbb(ram_csbb), .ram_rebb(ram_rebb),
        .ram_webb(ram_webb), .ram_oebb(ram_oebb), .ram_ib(ram_ib),
        .ram_ob(ram_ob)
    );

    always #5 clk = ~clk;

    // rdpb18 macro: synchronous write on A, registered read data on B.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!ram_csba && !ram_weba) mem[ram_aa] <= ram_ia;
        if (!ram_csbb && !ram_rebb) ram_ob <= mem[ram_ab];
    end

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    logic [DW-1:0] q[$];
    logic          wr_last = 1'b0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] held = '0;
    logic          gapchk = 1'b0;
    logic          seen_out = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: check state at the falling edge, drive, settle, update the model.
    task automatic step(input logic sv, input logic [DW-1:0] d, input logic mr);
        @(negedge clk);
        check("count", 32'(count), 32'(q.size()));
        if (q.size() == 0) check("empty_mvalid", 32'(m_valid), 32'd0);
        if (prev_hold) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", 32'(m_data), 32'(held));
        end
        if (gapchk && seen_out && q.size() != 0) check("nogap", 32'(m_valid), 32'd1);
        if (gapchk) check("count_le3", 32'(count <= 3), 32'd1);
        s_valid = sv;
        s_data  = d;
        m_ready = mr;
        #1;
        if (q.size() < DEPTH) check("s_ready", 32'(s_ready), 32'd1);
        if (!ram_csba && !ram_csbb) check("collide", 32'(ram_aa == ram_ab), 32'd0);
        wr_last = s_valid && s_ready;
        if (m_valid && m_ready && q.size() != 0) begin
            check("data", 32'(m_data), 32'(q[0]));
            void'(q.pop_front());
            seen_out = 1'b1;
        end
        if (wr_last) q.push_back(d);
        prev_hold = m_valid && !m_ready;
        held      = m_data;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && q.size() != 0; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        @(negedge clk);
        check("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned acc;
        int unsigned pushed;

        // reset with a pending write request
        xrst = 1'b0; clr = 1'b0; s_valid = 1'b1; s_data = 16'hAAAA; m_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_s_ready", 32'(s_ready), 32'd0);
            check("rst_weba", 32'(ram_weba), 32'd1);
            check("rst_m_valid", 32'(m_valid), 32'd0);
            check("rst_count", 32'(count), 32'd0);
        end
        s_valid = 1'b0;
        xrst    = 1'b1;
        @(negedge clk);
        check("rel_s_ready", 32'(s_ready), 32'd1);

        // single-word latency
        step(1'b1, 16'h1234, 1'b1);
        @(negedge clk);
        check("lat_rebb_t", 32'(ram_rebb), 32'd0);
        check("lat_mv_t", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("lat_rebb_t1", 32'(ram_rebb), 32'd1);
        check("lat_mv_t1", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("lat_mv_t2", 32'(m_valid), 32'd1);
        check("lat_data", 32'(m_data), 32'h1234);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // continuous streaming through two pointer wraps
        gapchk = 1'b1; seen_out = 1'b0;
        for (int i = 0; i < 300; i++) step(1'b1, 16'(i), 1'b1);
        drain();
        gapchk = 1'b0;

        // fill until backpressure
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 16'(16'h4000 + i), 1'b0);
            if (!wr_last) break;
            acc++;
        end
        check("fill_acc", acc, 32'd130);
        @(negedge clk);
        check("fill_count", 32'(count), 32'd130);
        check("fill_s_ready", 32'(s_ready), 32'd0);
        drain();
        check("fill_s_ready_back", 32'(s_ready), 32'd1);

        // random traffic on both sides
        pushed = 0;
        for (int c = 0; c < 20000 && pushed < 2000; c++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
            if (wr_last) pushed++;
        end
        check("bp_pushed", pushed, 32'd2000);
        drain();

        // flush with a read in flight
        for (int i = 0; i < 51; i++) step(1'b1, 16'(16'h2000 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        @(negedge clk);
        check("flush_pre_count", 32'(count), 32'd50);
        clr = 1'b1; s_valid = 1'b1; s_data = 16'h5555; m_ready = 1'b1;
        #1;
        check("flush_s_ready", 32'(s_ready), 32'd0);
        check("flush_csba", 32'(ram_csba), 32'd1);
        check("flush_csbb", 32'(ram_csbb), 32'd1);
        @(posedge clk);
        #1;
        clr = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        q.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        check("flush_count", 32'(count), 32'd0);
        check("flush_m_valid", 32'(m_valid), 32'd0);
        step(1'b1, 16'hBEEF, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);
        @(negedge clk);
        check("beef_first", 32'(m_data), 32'hBEEF);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- Synchronous FIFO controller that turns one rdpb18 dual-port SRAM macro into a streaming buffer.
  - Macro port A is write-only.
  - Macro port B is read-only.
- Hides the macro's one-cycle read latency behind a 2-entry output buffer, so valid/ready streams run at one word per cycle.
- Sits between pipeline stages; the top level wires CPA and CPB of the macro to clk.

Parameters:
- DWIDTH, 16, data width; must equal the macro's numout (8/16/18/24/32).
- AWIDTH, 7, address width; macro depth is 2**AWIDTH (6..9).

Ports:
- clk  in  1  system clock; also drives macro CPA/CPB.
- xrst  in  1  reset, synchronous, active-low.
- clr  in  1  synchronous flush, active-high; same effect as reset on controller state.
- s_valid  in  1  write request.
- s_ready  out  1  write accepted when s_valid&s_ready at a rising edge.
- s_data  in  DWIDTH  write data.
- m_valid  out  1  output word available.
- m_ready  in  1  consumer accepts when m_valid&m_ready.
- m_data  out  DWIDTH  output word (head of FIFO).
- count  out  AWIDTH+2  total words held (RAM + in-flight + output buffer).
- ram_aa  out  AWIDTH  macro AA = wr_ptr.
- ram_csba, ram_weba  out  1  macro CSBA/WEBA; both = ~wr_en.
- ram_reba, ram_oeba  out  1  constant 1.
- ram_ia  out  DWIDTH  = s_data.
- ram_ab  out  AWIDTH  macro AB = rd_ptr.
- ram_csbb, ram_rebb  out  1  both = ~rd_en.
- ram_webb  out  1  constant 1.
- ram_oebb  out  1  constant 0.
- ram_ib  out  DWIDTH  constant 0.
- ram_ob  in  DWIDTH  macro OB; valid in the cycle after a read strobe is sampled.

Behaviour:
- Reset/clr at a rising edge, regardless of other inputs:
  - wr_ptr, rd_ptr, ram_used, inflight, obuf_cnt = 0.
  - m_data = 0, m_valid = 0, count = 0.
  - RAM contents are not cleared.
  - An in-flight read's OB is discarded.
  - While xrst=0 or clr=1: s_ready=0, and all macro strobes are high (no access).
- State:
  - ram_used (0..DEPTH), committed words in RAM.
  - inflight (0/1), read strobe issued last cycle.
  - obuf_cnt (0..2): head register plus skid register.
- Write path:
  - s_ready = (ram_used != DEPTH).
  - wr_en = s_valid & s_ready.
  - On wr_en: wr_ptr increments mod DEPTH (natural wrap) and ram_used increments.
- Read issue:
  - pop = m_valid & m_ready.
  - rd_en = (ram_used != 0) & (obuf_cnt + inflight - pop <= 1).
  - On rd_en: rd_ptr increments mod DEPTH, ram_used decrements, and inflight is set next cycle; otherwise inflight clears.
- Simultaneous wr_en and rd_en: ram_used is unchanged.
- rd_en never targets a word written in the same cycle, because ram_used counts only committed writes. Therefore the macro never sees same-address A-write/B-read in one cycle.
- Capture: when inflight=1, ram_ob is written into the head register if the buffer is empty after pop, otherwise into the skid register.
- Pop: the skid moves to the head, and obuf_cnt adjusts (+capture, -pop).
- m_valid = (obuf_cnt != 0); m_data = head register.
  - Both are registered and held stable while m_valid & ~m_ready.
- Latency: a word accepted at edge t, into an empty FIFO, gives m_valid=1 after edge t+2 (read sampled at t+1, captured at t+2).
- Throughput: 1 word/cycle sustained with s_valid=m_ready=1.
- count = ram_used + inflight + obuf_cnt. Maximum is DEPTH+2; the width covers it.
- Full: with ram_used=DEPTH, s_ready is low. A simultaneous pop frees a RAM slot only via rd_en; s_ready rises the cycle after ram_used drops.
- Empty: with count=0, m_valid=0 and no read strobe is issued.
- m_ready while m_valid=0 has no effect.

Test Plan:
- Reset: hold xrst=0 for 2 cycles with s_valid=1 -> s_ready=0, ram_weba=1, m_valid=0, count=0. Release -> s_ready=1 next cycle.
- Latency: AWIDTH=7, push single word 0x1234 at edge t with m_ready=1 -> ram_rebb=0 in cycle t..t+1, m_valid=1 with m_data=0x1234 after edge t+2, count returns to 0 after the pop.
- Streaming: push 0..299 continuously with m_ready=1 -> output 0..299 in order, no gaps after the first word, pointers wrap twice, count stays ≤3.
- Fill: m_ready=0, push until s_ready=0 -> 130 words accepted (128 RAM + 2 buffer), count=130. Then m_ready=1 -> all 130 words drain in order and s_ready re-asserts.
- Backpressure: random m_ready (50%) and random s_valid over 2000 words -> scoreboard matches, and m_data stays stable while m_valid&~m_ready.
- Flush: pulse clr with count=50 and a read in flight -> count=0 and m_valid=0 next cycle. A subsequent push of 0xBEEF is the first word out.
